// File: rtl/stopwatch_time_counter.sv
// MM:SS.CC BCD stopwatch datapath: prescaled centisecond cascade plus a
// lap-freezable registered display copy and a one-clock wrap pulse.
module stopwatch_time_counter #(
    parameter int unsigned TICKS_PER_CS = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic        counting,
    input  logic        reset_timer,
    input  logic        lap_hold,
    output logic [23:0] disp_bcd,
    output logic        rollover
);

    localparam logic [7:0] PRE_MAX = 8'(TICKS_PER_CS - 1);

    logic [7:0]  pre_q, pre_d;
    logic [23:0] live_q, live_d;
    logic [23:0] disp_q, disp_d;
    logic        rollover_q, rollover_d;
    logic        advance;
    logic        cs_tick;
    logic        carry;

    always_comb begin
        advance    = clk_en && counting;
        cs_tick    = advance && (pre_q == PRE_MAX);
        pre_d      = pre_q;
        live_d     = live_q;
        carry      = cs_tick;
        disp_d     = lap_hold ? disp_q : live_q;

        if (advance) begin
            pre_d = cs_tick ? 8'd0 : pre_q + 8'd1;
        end

        // Ripple the tick from cs_o upward; sec_t and min_t (digits 3 and 5) wrap at 5.
        for (int i = 0; i < 6; i++) begin
            if (carry) begin
                if (live_q[4*i +: 4] == (((i == 3) || (i == 5)) ? 4'd5 : 4'd9)) begin
                    live_d[4*i +: 4] = 4'd0;
                end else begin
                    live_d[4*i +: 4] = live_q[4*i +: 4] + 4'd1;
                    carry            = 1'b0;
                end
            end
        end

        rollover_d = carry;

        if (reset_timer) begin
            pre_d      = 8'd0;
            live_d     = 24'h0;
            disp_d     = 24'h0;
            rollover_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q      <= 8'd0;
            live_q     <= 24'h0;
            disp_q     <= 24'h0;
            rollover_q <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            live_q     <= live_d;
            disp_q     <= disp_d;
            rollover_q <= rollover_d;
        end
    end

    assign disp_bcd = disp_q;
    assign rollover = rollover_q;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Bench for stopwatch_time_counter: a strobe-count reference model checked every
// cycle, plus directed scenarios pinned to hand-computed display values.
module tb_stopwatch_time_counter;

    localparam int     T    = 10;
    localparam longint FULL = 64'd360000 * T;

    logic        clk         = 1'b0;
    logic        rst_n       = 1'b0;
    logic        clk_en      = 1'b0;
    logic        counting    = 1'b0;
    logic        reset_timer = 1'b0;
    logic        lap_hold    = 1'b0;
    logic [23:0] disp_bcd;
    logic        rollover;

    int tests = 0;
    int fails = 0;

    // Reference model: total counted strobes since the last clear.
    longint      m_n    = 0;
    logic [23:0] m_disp = 24'h0;
    logic        m_roll = 1'b0;
    longint      m_base;
    longint      m_next;
    logic        m_wrap;

    logic        preload_pending = 1'b0;
    longint      preload_n       = 0;
    logic [23:0] preload_bcd     = 24'h0;
    logic        chk_en          = 1'b0;

    stopwatch_time_counter #(.TICKS_PER_CS(T)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_en      (clk_en),
        .counting    (counting),
        .reset_timer (reset_timer),
        .lap_hold    (lap_hold),
        .disp_bcd    (disp_bcd),
        .rollover    (rollover)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] to_bcd(input longint cs);
        int mm, ss, cc;
        mm = int'(cs / 6000);
        ss = int'((cs / 100) % 60);
        cc = int'(cs % 100);
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n    <= 0;
            m_disp <= 24'h0;
            m_roll <= 1'b0;
        end else if (reset_timer) begin
            m_n    <= 0;
            m_disp <= 24'h0;
            m_roll <= 1'b0;
        end else begin
            m_base = preload_pending ? preload_n : m_n;
            m_next = m_base;
            m_wrap = 1'b0;
            if (clk_en && counting) begin
                m_next = m_base + 1;
                if (m_next == FULL) begin
                    m_next = 0;
                    m_wrap = 1'b1;
                end
            end
            m_n    <= m_next;
            m_roll <= m_wrap;
            if (!lap_hold) m_disp <= to_bcd(m_base / T);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            tests = tests + 1;
            if (disp_bcd !== m_disp) begin
                fails = fails + 1;
                $display("[TB] FAIL model_disp at %0t: got %h, want %h", $time, disp_bcd, m_disp);
            end
            tests = tests + 1;
            if (rollover !== m_roll) begin
                fails = fails + 1;
                $display("[TB] FAIL model_rollover at %0t: got %b, want %b", $time, rollover, m_roll);
            end
        end
    end

    task automatic applyStimulus(input logic ce, input logic cnt, input logic rt, input logic lap);
        clk_en      = ce;
        counting    = cnt;
        reset_timer = rt;
        lap_hold    = lap;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic strobes(input int n, input logic cnt, input logic lap);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, cnt, 1'b0, lap);
    endtask

    task automatic checkOutput(input string name, input logic [23:0] exp_disp, input logic exp_roll);
        tests = tests + 1;
        if (disp_bcd !== exp_disp || rollover !== exp_roll) begin
            fails = fails + 1;
            $display("[TB] FAIL %s: got disp=%h roll=%b, want disp=%h roll=%b",
                     name, disp_bcd, rollover, exp_disp, exp_roll);
        end
    endtask

    // Jump the live count to a given centisecond value without disturbing the prescaler.
    task automatic preload(input longint cs);
        preload_bcd = to_bcd(cs);
        preload_n   = cs * T + (m_n % T);
        force dut.live_q = preload_bcd;
        preload_pending = 1'b1;
        #1;
        release dut.live_q;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        preload_pending = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        checkOutput("reset_state", 24'h000000, 1'b0);

        strobes(10, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("first_cs", 24'h000001, 1'b0);

        preload(5999);
        strobes(10, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("minute_carry", 24'h010000, 1'b0);

        preload(359999);
        strobes(9, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("wrap_pulse", 24'h595999, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("wrap_after", 24'h000000, 1'b0);

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        strobes(7, 1'b1, 1'b0);
        strobes(100, 1'b0, 1'b0);
        strobes(3, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("pause_fraction", 24'h000001, 1'b0);

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        strobes(12340, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("lap_start", 24'h001234, 1'b0);
        strobes(500, 1'b1, 1'b1);
        checkOutput("lap_frozen", 24'h001234, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("lap_release", 24'h001284, 1'b0);

        strobes(25, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("clear_over_lap", 24'h000000, 1'b0);

        preload(359999);
        strobes(9, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("clear_suppresses_wrap", 24'h000000, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("clear_live_zero", 24'h000000, 1'b0);

        strobes(25, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("pre_async", 24'h000002, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 24'h000000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        strobes(10, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("post_reset_count", 24'h000001, 1'b0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
